// File: rtl/param_crossbar_pkg.sv
// crossbar_pkg: opcodes, sub-action field offsets, container widths and the per-op operand routing rule.
package crossbar_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SET   = 4'b1110;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOADD = 4'b0111;
  // the op field ends OP_MSB bits below ACT_LEN, so it tracks the sub-action width
  localparam int OP_MSB = 1;
  localparam int OP_W   = 4;
  localparam int IDXA   = 16;
  localparam int IDXB   = 11;
  localparam int IDX_W  = 3;
  localparam int IMM    = 0;
  localparam int IMM_W  = 16;
  localparam int W6 = 48;
  localparam int W4 = 32;
  localparam int W2 = 16;
  typedef enum logic [1:0] {SA_ZERO, SA_SELF, SA_IDX} a_sel_e;
  typedef enum logic [1:0] {SB_ZERO, SB_IMM, SB_IDX} b_sel_e;
  typedef struct packed {
    a_sel_e a;
    b_sel_e b;
  } dec_t;
  function automatic dec_t decode_op(input logic [3:0] op, input logic mem_ops);
    dec_t d;
    d = '{a: SA_SELF, b: SB_ZERO};
    if (op == OP_ADD || op == OP_SUB || (mem_ops && (op == OP_LOAD || op == OP_STORE || op == OP_LOADD)))
      d = '{a: SA_IDX, b: SB_IDX};
    else if (op == OP_ADDI || op == OP_SUBI)
      d = '{a: SA_IDX, b: SB_IMM};
    else if (op == OP_SET)
      d = '{a: SA_ZERO, b: SB_IMM};
    return d;
  endfunction
endpackage

// File: rtl/param_crossbar_if.sv
// param_crossbar_if: PHV/action input handshake and decoded-operand output handshake.
interface param_crossbar_if #(
  parameter int N6 = 8,
  parameter int N4 = 8,
  parameter int N2 = 8,
  parameter int ACT_LEN = 25,
  parameter int META_LEN = 356
);
  localparam int NACT = N6 + N4 + N2 + 1;
  localparam int PHV_LEN = 48*N6 + 32*N4 + 16*N2 + META_LEN;
  logic [PHV_LEN-1:0] phv_in;
  logic phv_in_valid;
  logic [ACT_LEN*NACT-1:0] action_in;
  logic action_in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [48*N6-1:0] alu_6B_1, alu_6B_2;
  logic [32*N4-1:0] alu_4B_1, alu_4B_2, alu_4B_3;
  logic [16*N2-1:0] alu_2B_1, alu_2B_2;
  logic [META_LEN-1:0] meta_out;
  logic [ACT_LEN*NACT-1:0] action_out;
  logic [11:0] vlan_id;
  logic [15:0] join_err_cnt;
  modport slave (
    input phv_in, phv_in_valid, action_in, action_in_valid, out_ready,
    output in_ready, out_valid, alu_6B_1, alu_6B_2, alu_4B_1, alu_4B_2, alu_4B_3,
    output alu_2B_1, alu_2B_2, meta_out, action_out, vlan_id, join_err_cnt
  );
  modport master (
    output phv_in, phv_in_valid, action_in, action_in_valid, out_ready,
    input in_ready, out_valid, alu_6B_1, alu_6B_2, alu_4B_1, alu_4B_2, alu_4B_3,
    input alu_2B_1, alu_2B_2, meta_out, action_out, vlan_id, join_err_cnt
  );
endinterface

// File: rtl/param_crossbar_fifo.sv
// xbar_skid_fifo: 2-entry register FIFO forming the crossbar output stage.
module xbar_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp, wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wp ^ wr;
      rp <= rp ^ rd;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  assign dout = mem[rp];
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
endmodule

// File: rtl/param_crossbar.sv
// param_crossbar: decodes per-container sub-actions into ALU operands and buffers them in a 2-entry output FIFO.
module param_crossbar
  import crossbar_pkg::*;
#(
  parameter int N6 = 8,
  parameter int N4 = 8,
  parameter int N2 = 8,
  parameter int ACT_LEN = 25,
  parameter int META_LEN = 356,
  parameter int VLAN_LSB = 129
) (
  input logic clk,
  input logic rst,
  param_crossbar_if.slave bus
);
  localparam int NACT = N6 + N4 + N2 + 1;
  localparam int O2 = META_LEN;
  localparam int O4 = O2 + W2*N2;
  localparam int O6 = O4 + W4*N4;
  localparam int A2 = ACT_LEN;
  localparam int A4 = A2 + ACT_LEN*N2;
  localparam int A6 = A4 + ACT_LEN*N4;
  localparam int DW = 2*W6*N6 + 3*W4*N4 + 2*W2*N2 + META_LEN + ACT_LEN*NACT;
  logic [W6-1:0] c6 [8];
  logic [W4-1:0] c4 [8];
  logic [W2-1:0] c2 [8];
  logic [W6*N6-1:0] a6, b6;
  logic [W4*N4-1:0] a4, b4, c4o;
  logic [W2*N2-1:0] a2, b2;
  logic [DW-1:0] din, dout;
  logic [1:0] count;
  logic push, pop, full, empty;
  // slots past a class's count read as zero, which makes out-of-range indices select zero
  for (genvar k = 0; k < 8; k++) begin : g_cont
    if (k < N6) begin : g6
      assign c6[k] = bus.phv_in[O6 + W6*k +: W6];
    end else begin : z6
      assign c6[k] = '0;
    end
    if (k < N4) begin : g4
      assign c4[k] = bus.phv_in[O4 + W4*k +: W4];
    end else begin : z4
      assign c4[k] = '0;
    end
    if (k < N2) begin : g2
      assign c2[k] = bus.phv_in[O2 + W2*k +: W2];
    end else begin : z2
      assign c2[k] = '0;
    end
  end
  for (genvar i = 0; i < N6; i++) begin : g_dec6
    logic [ACT_LEN-1:0] act;
    dec_t d;
    assign act = bus.action_in[A6 + ACT_LEN*i +: ACT_LEN];
    assign d = decode_op(act[ACT_LEN-OP_MSB -: OP_W], 1'b0);
    assign a6[W6*i +: W6] = d.a == SA_IDX ? c6[act[IDXA +: IDX_W]] : d.a == SA_SELF ? c6[i] : '0;
    assign b6[W6*i +: W6] = d.b == SB_IDX ? c6[act[IDXB +: IDX_W]] : d.b == SB_IMM ? W6'(act[IMM +: IMM_W]) : '0;
  end
  for (genvar i = 0; i < N4; i++) begin : g_dec4
    logic [ACT_LEN-1:0] act;
    dec_t d;
    assign act = bus.action_in[A4 + ACT_LEN*i +: ACT_LEN];
    assign d = decode_op(act[ACT_LEN-OP_MSB -: OP_W], 1'b1);
    assign a4[W4*i +: W4] = d.a == SA_IDX ? c4[act[IDXA +: IDX_W]] : d.a == SA_SELF ? c4[i] : '0;
    assign b4[W4*i +: W4] = d.b == SB_IDX ? c4[act[IDXB +: IDX_W]] : d.b == SB_IMM ? W4'(act[IMM +: IMM_W]) : '0;
    assign c4o[W4*i +: W4] = c4[i];
  end
  for (genvar i = 0; i < N2; i++) begin : g_dec2
    logic [ACT_LEN-1:0] act;
    dec_t d;
    assign act = bus.action_in[A2 + ACT_LEN*i +: ACT_LEN];
    assign d = decode_op(act[ACT_LEN-OP_MSB -: OP_W], 1'b0);
    assign a2[W2*i +: W2] = d.a == SA_IDX ? c2[act[IDXA +: IDX_W]] : d.a == SA_SELF ? c2[i] : '0;
    assign b2[W2*i +: W2] = d.b == SB_IDX ? c2[act[IDXB +: IDX_W]] : d.b == SB_IMM ? W2'(act[IMM +: IMM_W]) : '0;
  end
  assign push = bus.phv_in_valid & bus.action_in_valid & ~full;
  assign pop = bus.out_valid & bus.out_ready;
  assign din = {a6, b6, a4, b4, c4o, a2, b2, bus.phv_in[META_LEN-1:0], bus.action_in};
  xbar_skid_fifo #(.W(DW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout),
    .count(count), .full(full), .empty(empty)
  );
  assign bus.in_ready = count < 2'd2;
  assign bus.out_valid = ~empty;
  assign {bus.alu_6B_1, bus.alu_6B_2, bus.alu_4B_1, bus.alu_4B_2, bus.alu_4B_3,
          bus.alu_2B_1, bus.alu_2B_2, bus.meta_out, bus.action_out} = dout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.vlan_id <= '0;
      bus.join_err_cnt <= '0;
    end else begin
      if (push) bus.vlan_id <= bus.phv_in[VLAN_LSB +: 12];
      if ((bus.phv_in_valid ^ bus.action_in_valid) && bus.join_err_cnt != 16'hFFFF)
        bus.join_err_cnt <= bus.join_err_cnt + 16'd1;
    end
endmodule

// File: doc/param_crossbar.md
PARAM_CROSSBAR -- requirements
Module: param_crossbar

Interface
REQ-001 Parameters (name, default, meaning):
- N6 = 8: 6B containers per PHV, 1..8.
- N4 = 8: 4B containers, 1..8.
- N2 = 8: 2B containers, 1..8.
- ACT_LEN = 25: bits per sub-action.
- META_LEN = 356: trailing metadata bits.
- VLAN_LSB = 129: LSB of the 12-bit VLAN field in the PHV.
REQ-002 Derived widths: NACT = N6+N4+N2+1; PHV_LEN = 48*N6 + 32*N4 + 16*N2 + META_LEN.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- phv_in, in, PHV_LEN, containers MSB-first: 6B[N6-1..0], 4B[N4-1..0], 2B[N2-1..0], then metadata.
- phv_in_valid, in, 1, PHV present.
- action_in, in, ACT_LEN*NACT, sub-actions MSB-first: 6B[N6-1..0], 4B, 2B, then the spare (LSB) sub-action.
- action_in_valid, in, 1, action present.
- in_ready, out, 1, block can accept.
- out_valid, out, 1, output entry valid.
- out_ready, in, 1, downstream accepts.
- alu_6B_1 / alu_6B_2, out, 48*N6, operands A/B for 6B ALUs.
- alu_4B_1 / alu_4B_2 / alu_4B_3, out, 32*N4, operands A/B/C for 4B ALUs.
- alu_2B_1 / alu_2B_2, out, 16*N2, operands A/B for 2B ALUs.
- meta_out, out, META_LEN, metadata passthrough.
- action_out, out, ACT_LEN*NACT, action aligned with operands.
- vlan_id, out, 12, VLAN of the last accepted PHV.
- join_err_cnt, out, 16, saturating count of unpaired-valid cycles.

Function
REQ-005 Sub-action fields:
- op = [ACT_LEN-1 -: 4].
- idxA = [18:16].
- idxB = [13:11].
- imm = [15:0].
REQ-006 Accept occurs when phv_in_valid & action_in_valid & in_ready; the PHV and its action are consumed in the same cycle.
REQ-007 join_err_cnt increments by 1 each cycle where phv_in_valid XOR action_in_valid, and saturates at 0xFFFF.
REQ-008 Per-container decode, for container i of class W:
- op 0001/0010: A=cont_W[idxA], B=cont_W[idxB].
- op 1001/1010: A=cont_W[idxA], B=zero-extended imm.
- op 1110: A=0, B=zero-extended imm.
- 4B class only, op 1011/1000/0111: A=cont_4B[idxA], B=cont_4B[idxB].
- any other op: A=cont_W[i], B=0.
REQ-009 An idxA or idxB >= the class count selects zero for that operand.
REQ-010 alu_4B_3 slot i always equals cont_4B[i] of the accepted PHV.
REQ-011 meta_out = phv_in[META_LEN-1:0] and action_out = action_in, both captured with the accepted PHV.
REQ-012 vlan_id loads phv_in[VLAN_LSB+11:VLAN_LSB] on accept and otherwise holds.
REQ-013 Decoded results are pushed into a 2-entry FIFO, which forms the output stage.
REQ-014 out_valid = FIFO not empty; outputs show the head entry; the head is popped when out_valid & out_ready.
REQ-015 in_ready = FIFO count < 2, registered, independent of out_ready.
REQ-016 Latency: accept at cycle T gives out_valid at T+1 when the FIFO is empty.
REQ-017 Push and pop in the same cycle with count 1: count stays 1 and the new entry becomes head at T+1.
REQ-018 With count 2, no push occurs and pop drops count to 1; in_ready rises the following cycle.
REQ-019 Output fields must hold while out_valid & ~out_ready (no change under backpressure).
REQ-020 Ordering is strictly FIFO; no entry is dropped or duplicated.

Reset
REQ-021 Reset values:
- FIFO count = 0.
- out_valid = 0.
- in_ready = 1 after deassertion.
- all operand, meta, action and vlan outputs = 0.
- join_err_cnt = 0.
REQ-022 Reset asserted mid-operation discards all buffered entries immediately (asynchronously); the first post-reset accept behaves as into an empty FIFO.

Structure
REQ-023 Package crossbar_pkg holds:
- opcode constants (OP_ADD=0001, OP_SUB=0010, OP_ADDI=1001, OP_SUBI=1010, OP_SET=1110, OP_LOAD=1011, OP_STORE=1000, OP_LOADD=0111);
- field offsets (OP_MSB, IDXA, IDXB, IMM);
- container widths 48/32/16.
REQ-024 The 2-entry FIFO is sub-module xbar_skid_fifo, parameterised by data width, with push/pop/count/full/empty.
REQ-025 Decode is combinational ahead of the FIFO; every output comes from FIFO registers.

Verification
REQ-026 Directed scenarios:
- Defaults; 6B slot 3 op 0001, idxA=5, idxB=2; cont_6B[5]=0x1, cont_6B[2]=0x2 -> T+1: alu_6B_1 slot3=0x1, alu_6B_2 slot3=0x2, out_valid=1.
- 2B slot 0 op 1110, imm=0xBEEF -> alu_2B_1 slot0=0, alu_2B_2 slot0=0xBEEF; other slots A=cont[i], B=0.
- N4=4; 4B slot 1 op 1001, idxA=6, imm=0x0010 -> alu_4B_1 slot1=0 (index out of range), alu_4B_2 slot1=0x00000010, alu_4B_3 slot1=cont_4B[1].
- out_ready=0, three back-to-back accept attempts -> two accepted, in_ready=0 from the cycle after the second; then out_ready=1 -> entries emerge in order, outputs stable while stalled.
- phv_in_valid=1, action_in_valid=0 for 5 cycles -> no accept, join_err_cnt=5; preload 0xFFFE, 3 more cycles -> 0xFFFF.
- FIFO full, assert rst for 1 cycle -> out_valid=0 and all outputs 0 immediately; in_ready=1 after release; next accept appears at T+1.
